jmp_issue: RTL and testbench
============================

# jmp_issue

Source-side issuer for the 64-bit instruction-word stream consumed by the jump security filter. Accepts jump / non-jump instruction requests, formats each into the 64-bit word layout the filter decodes, tags it with a sequence number, and buffers it in a small FIFO behind a valid/ready output handshake. Optionally screens zero-target jumps at the source, so the filter never has to nullify a word in normal operation.

## Interface
- `DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `SEQ_W`, 16: sequence-tag width; 1..32.
- `J_OPC`, 6'd2: jump opcode value placed in word bits [31:26].
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_jump`  in  1  1 = jump request, 0 = raw instruction.
- `req_target`  in  26  jump target; used when `req_jump`=1.
- `req_payload`  in  32  raw instruction; used when `req_jump`=0.
- `o_valid`  out  1  `o_word` valid.
- `o_ready`  in  1  downstream accepts when `o_valid & o_ready`.
- `o_word`  out  64  formatted word.
- `drop_cnt`  out  16  saturating count of source-dropped zero-target jumps.
- `busy`  out  1  FIFO non-empty.

## Operation
- Word layout: [63:32] = sequence tag, zero-extended from `SEQ_W`; [31:0] = instruction.
- Jump request: instruction = {`J_OPC`, `req_target`}.
- Raw request: instruction = `req_payload`. If `req_payload[31:26]` == `J_OPC`, the request is classified as a jump with target `req_payload[25:0]`. One classification rule therefore matches the downstream decoder.
- Zero-target jump: effective jump with target == 0; handling is set by the configuration macro.
- Sequence counter `seq`: increments once per word written to the FIFO, never for dropped requests. Wraps from 2^SEQ_W−1 to 0.
- FIFO: circular, read/write pointers plus a count of `$clog2(DEPTH)+1` bits.
- Occupancy states:
  - EMPTY (count 0)
  - PARTIAL (0 < count < DEPTH)
  - FULL (count = DEPTH)
- State transitions on push/pop. Push and pop in the same cycle leave the count unchanged.
- `req_ready` = state ≠ FULL, registered from the state. In FULL, no push is taken even if a pop occurs that cycle.
- `o_valid` = state ≠ EMPTY. `o_word` = head entry, driven straight from FIFO storage.
- `busy` = `o_valid`.

## Timing
- Reset values:
  - `req_ready`=1 (EMPTY)
  - `o_valid`=0
  - `o_word`=0
  - `drop_cnt`=0
  - `busy`=0
  - `seq`=0
  - pointers 0
  - storage cleared to 0
- Reset asserted mid-stream: all in-flight words are discarded immediately; no partial word is emitted after release.
- Latency: request accepted at edge N → word visible on `o_word` with `o_valid`=1 after edge N (one cycle) when the FIFO was EMPTY.
- Output is stable while `o_valid & ~o_ready`: the head never changes without a pop.
- Back-to-back: one request per cycle and one word per cycle sustained when `o_ready`=1.
- Dropped request: handshake completes (`req_ready` honoured). No FIFO write, no `seq` change. `drop_cnt` increments at the same edge and saturates at 16'hFFFF.

## Configuration
- `JMP_ISSUE_ZERO_GUARD_EN` defined: zero-target jumps are accepted and dropped at the source, and `drop_cnt` counts them.
- Undefined: zero-target jumps are emitted as normal words, and the downstream filter nullifies them. `drop_cnt` is tied to 0 and its logic is removed.

## Structure
- Shared package `jmp_pkg` holds:
  - `J_OPC_DEFAULT`
  - field position constants: `OPC_LSB`=26, `OPC_W`=6, `TGT_W`=26, `TAG_LSB`=32
  - a packed typedef `instr_word_t` {tag[31:0], opc[5:0], tgt[25:0]}
- One sub-module: `jmp_issue_fifo`, a generic DEPTH × 64 synchronous FIFO that provides the count/state and the full/empty flags. Formatting, classification, the guard and the counters stay in `jmp_issue`.

## Test plan
- Reset, then jump request target 26'h0000123, `o_ready`=1 → next cycle `o_word`=64'h0000_0000_0800_0123, `o_valid`=1 for one cycle.
- Raw request payload 32'h0800_0040 (opcode 2) → treated as a jump; word 64'h0000_0000_0800_0040 with tag 0. A second raw request 32'h2002_0005 → tag 1.
- With guard defined, jump target 0 → no output, `drop_cnt`=1, and the next valid word carries the unchanged tag. Without guard → word 64'h…_0800_0000 is emitted.
- `o_ready`=0, push 4 requests → `req_ready`=0 after the 4th, `o_word` holds the first. Raise `o_ready` → 4 words in order, tags 0..3.
- FULL with `req_valid`=1 and `o_ready`=1 for one cycle → one pop, no push; `req_ready`=1 the following cycle.
- Assert `rst_n`=0 with 3 words queued → `o_valid`=0 immediately, and tag restarts at 0 after release.

Source files
------------

// File: rtl/jmp_pkg.sv
// Shared field layout, occupancy encoding and default opcode for the jump issuer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package jmp_pkg;

    localparam logic [5:0] J_OPC_DEFAULT = 6'd2;

    // Bit positions of the 64-bit word the jump filter decodes
    localparam int OPC_LSB = 26;
    localparam int OPC_W   = 6;
    localparam int TGT_W   = 26;
    localparam int TAG_LSB = 32;

    typedef struct packed {
        logic [31:0]      tag;
        logic [OPC_W-1:0] opc;
        logic [TGT_W-1:0] tgt;
    } instr_word_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

endpackage

// File: rtl/jmp_issue_if.sv
// Request and output-word handshake bundle of the jump issuer.
// Latency: none (wiring only).
// Backpressure: req_ready throttles requests, o_ready throttles words.
interface jmp_issue_if;
    import jmp_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_jump;
    logic [TGT_W-1:0] req_target;
    logic [31:0]      req_payload;
    logic             o_valid;
    logic             o_ready;
    logic [63:0]      o_word;

    // Requester / word consumer side
    modport master (
        output req_valid, req_jump, req_target, req_payload, o_ready,
        input  req_ready, o_valid, o_word
    );

    // Issuer side
    modport slave (
        input  req_valid, req_jump, req_target, req_payload, o_ready,
        output req_ready, o_valid, o_word
    );

endinterface

// File: rtl/jmp_issue_fifo.sv
// Generic DEPTH x W circular FIFO with EMPTY/PARTIAL/FULL occupancy tracking.
// Latency: a pushed entry is readable on rdata one cycle after the push edge.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
module jmp_issue_fifo
    import jmp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    occ_state_t    state_q, state_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Flags come straight from the registered state so ready/valid never depend on inputs
    assign full    = (state_q == OCC_FULL);
    assign empty   = (state_q == OCC_EMPTY);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Next pointers, count, occupancy state and storage
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        mem_d    = mem_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (cnt_d == '0) begin
            state_d = OCC_EMPTY;
        end else if (cnt_d == CW'(DEPTH)) begin
            state_d = OCC_FULL;
        end else begin
            state_d = OCC_PARTIAL;
        end
    end

    // State register; reset clears storage so the head reads zero while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= OCC_EMPTY;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/jmp_issue.sv
// Formats jump/raw requests into sequence-tagged 64-bit words and queues them for the jump filter.
// Latency: accepted request appears on o_word one cycle later when the queue was empty.
// Backpressure: req_ready low while the queue is full; head held until o_ready.
// Option JMP_ISSUE_ZERO_GUARD_EN: drop zero-target jumps at the source and count them.
module jmp_issue
    import jmp_pkg::*;
#(
    parameter int               DEPTH = 4,
    parameter int               SEQ_W = 16,
    parameter logic [OPC_W-1:0] J_OPC = J_OPC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    jmp_issue_if.slave  bus,
    output logic [15:0] drop_cnt,
    output logic        busy
);

    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [TAG_LSB-1:0] instr;
    instr_word_t        word;
    logic               accept;
    logic               drop;
    logic               push;
    logic               full;
    logic               empty;

    // Build the instruction and the tagged word; raw payloads carrying the jump
    // opcode land in the same opc/tgt fields the filter decodes, so one rule classifies both
    always_comb begin
        instr    = bus.req_jump ? {J_OPC, bus.req_target} : bus.req_payload;
        word.tag = 32'(seq_q);
        word.opc = instr[OPC_LSB +: OPC_W];
        word.tgt = instr[TGT_W-1:0];
    end

    assign accept = bus.req_valid & bus.req_ready;

`ifdef JMP_ISSUE_ZERO_GUARD_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop = (word.opc == J_OPC) && (word.tgt == '0);

    // Saturating count of zero-target jumps swallowed here
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop     = 1'b0;
    assign drop_cnt = '0;
`endif

    // Dropped requests still complete their handshake but never reach the queue
    assign push = accept & ~drop;

    // Sequence tag advances only for words actually written
    always_comb begin
        seq_d = seq_q;
        if (push) begin
            seq_d = seq_q + SEQ_W'(1);
        end
    end

    // Sequence register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_d;
        end
    end

    jmp_issue_fifo #(
        .DEPTH (DEPTH),
        .W     (64)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (word),
        .pop   (bus.o_valid & bus.o_ready),
        .rdata (bus.o_word),
        .full  (full),
        .empty (empty)
    );

    assign bus.req_ready = ~full;
    assign bus.o_valid   = ~empty;
    assign busy          = ~empty;

endmodule

// File: tb/tb_jmp_issue.sv
module tb_jmp_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] drop_cnt;
    logic        busy;

    jmp_issue_if bus ();

    jmp_issue dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] sb [$];
    logic [15:0] m_seq;
    logic [15:0] m_drop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one accepted request
    task automatic model_accept();
        logic [31:0] instr;
        logic        drop_it;
        instr   = bus.req_jump ? {6'd2, bus.req_target} : bus.req_payload;
        drop_it = 1'b0;
`ifdef JMP_ISSUE_ZERO_GUARD_EN
        drop_it = (instr[31:26] == 6'd2) && (instr[25:0] == 26'd0);
`endif
        if (drop_it) begin
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end else begin
            sb.push_back({16'h0000, m_seq, instr});
            m_seq = m_seq + 16'd1;
        end
    endtask

    // Called at a falling edge with inputs set: scores the handshakes of the next rising edge
    task automatic step();
        #1;
        if (bus.o_valid === 1'b1 && bus.o_ready === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_word: observed %h expected no word", bus.o_word);
            end else begin
                check("pop_word", bus.o_word, sb.pop_front());
            end
        end
        if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) model_accept();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic jump, input logic [25:0] tgt, input logic [31:0] pl);
        bus.req_jump    = jump;
        bus.req_target  = tgt;
        bus.req_payload = pl;
        bus.req_valid   = 1'b1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_o_valid", bus.o_valid, 1'b0);
        check("rst_o_word", bus.o_word, 64'd0);
        check("rst_drop_cnt", drop_cnt, 16'd0);
        check("rst_busy", busy, 1'b0);
        sb.delete();
        m_seq  = 16'd0;
        m_drop = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_jump    = 1'b0;
        bus.req_target  = '0;
        bus.req_payload = '0;
        bus.o_ready     = 1'b1;
        m_seq           = 16'd0;
        m_drop          = 16'd0;
        @(negedge clk);
        do_reset();

        // Single jump request, one-cycle latency, valid for one cycle
        drive(1'b1, 26'h0000123, 32'd0);
        step();
        bus.req_valid = 1'b0;
        #1;
        check("t1_valid", bus.o_valid, 1'b1);
        check("t1_word", bus.o_word, 64'h0000_0000_0800_0123);
        step();
        #1;
        check("t1_one_cycle", bus.o_valid, 1'b0);

        // Raw payload with the jump opcode, then a plain raw instruction
        do_reset();
        drive(1'b0, 26'd0, 32'h0800_0040);
        step();
        drive(1'b0, 26'd0, 32'h2002_0005);
        #1;
        check("t2_word0", bus.o_word, 64'h0000_0000_0800_0040);
        step();
        bus.req_valid = 1'b0;
        #1;
        check("t2_word1", bus.o_word, 64'h0000_0001_2002_0005);
        step();

        // Zero-target jump request, then zero-target raw jump, then a normal jump
        drive(1'b1, 26'd0, 32'd0);
        step();
        bus.req_valid = 1'b0;
        #1;
`ifdef JMP_ISSUE_ZERO_GUARD_EN
        check("t3_drop_no_valid", bus.o_valid, 1'b0);
        check("t3_drop_cnt1", drop_cnt, 16'd1);
`else
        check("t3_emit_valid", bus.o_valid, 1'b1);
        check("t3_emit_word", bus.o_word, 64'h0000_0002_0800_0000);
        step();
`endif
        drive(1'b0, 26'd0, 32'h0800_0000);
        step();
        bus.req_valid = 1'b0;
        #1;
`ifdef JMP_ISSUE_ZERO_GUARD_EN
        check("t3_raw_drop_no_valid", bus.o_valid, 1'b0);
        check("t3_drop_cnt2", drop_cnt, 16'd2);
`else
        check("t3_raw_emit_word", bus.o_word, 64'h0000_0003_0800_0000);
        step();
`endif
        check("t3_drop_model", drop_cnt, m_drop);
        drive(1'b1, 26'h0000005, 32'd0);
        step();
        bus.req_valid = 1'b0;
        #1;
`ifdef JMP_ISSUE_ZERO_GUARD_EN
        check("t3_tag_unchanged", bus.o_word[63:32], 32'd2);
`else
        check("t3_tag_advanced", bus.o_word[63:32], 32'd4);
`endif
        step();

        // Fill to FULL with the output stalled
        do_reset();
        bus.o_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 26'd0, 32'h1000_0000 + 32'(i));
            step();
        end
        bus.req_valid = 1'b0;
        #1;
        check("t4_full_ready", bus.req_ready, 1'b0);
        check("t4_full_head", bus.o_word, 64'h0000_0000_1000_0000);
        check("t4_full_busy", busy, 1'b1);
        step();
        step();
        #1;
        check("t4_head_stable", bus.o_word, 64'h0000_0000_1000_0000);

        // FULL with both sides active: one pop, no push
        drive(1'b0, 26'd0, 32'h1000_00AA);
        bus.o_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        #1;
        check("t4_ready_after_pop", bus.req_ready, 1'b1);
        check("t4_next_head_tag", bus.o_word[63:32], 32'd1);
        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        #1;
        check("t4_drained", sb.size(), 0);
        check("t4_no_extra_word", bus.o_valid, 1'b0);

        // Reset with words in flight
        bus.o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 26'h0000010 + 26'(i), 32'd0);
            step();
        end
        bus.req_valid = 1'b0;
        #1;
        check("t5_busy_before", busy, 1'b1);
        do_reset();
        drive(1'b1, 26'h3FFFFFF, 32'd0);
        bus.o_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        #1;
        check("t5_tag_restart", bus.o_word[63:32], 32'd0);
        check("t5_word", bus.o_word, 64'h0000_0000_0BFF_FFFF);
        step();

        // Back-to-back streaming at one word per cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'(i % 2), 26'(i * 3 + 1), 32'hC000_0000 | 32'(i));
            step();
            check("t6_stream_valid", bus.o_valid, 1'b1);
        end
        bus.req_valid = 1'b0;
        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        #1;
        check("t6_drained", sb.size(), 0);
        check("t6_idle", bus.o_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
